// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   fetch_state_e : fetch FSM state encoding (ISSUE=00, WAIT=01, HOLD=10, SQUASH=11)
//   MIPS_NOP      : all-zero instruction word (sll $0,$0,0), used as the reset value of ir/ir_pc
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE  = 2'b00,
        ST_WAIT   = 2'b01,
        ST_HOLD   = 2'b10,
        ST_SQUASH = 2'b11
    } fetch_state_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch unit: samples the PC, issues one instruction-memory read,
// latches the returned word into the instruction register and holds it until
// decode accepts it. Branch/jump redirects reload the PC at once; a read already
// in flight is allowed to finish and its data is dropped.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   pc_addr               current PC value
//   pc_ld / pc_in         PC load strobe and load value (the redirect target)
//   pc_inc                PC +4 strobe, one pulse per accepted memory word
//   redirect, redirect_addr  single-cycle redirect request and target
//   imem_req / imem_addr  level read request and its address
//   imem_ack / imem_rdata read completion and returned instruction word
//   ir_valid / ir_ready   instruction-register handshake towards decode
//   ir / ir_pc            instruction word and the address it came from
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] IR_RESET = MIPS_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic [31:0] pc_in,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  ir_pc_q, ir_pc_d;
    logic         ir_valid_q, ir_valid_d;
    logic         req_d, inc_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ISSUE;
            addr_q     <= 32'h0000_0000;
            ir_q       <= IR_RESET;
            ir_pc_q    <= IR_RESET;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        req_d      = 1'b0;
        inc_d      = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                addr_d = pc_addr;
                // A redirect here reloads the PC; the new value is sampled next cycle.
                if (!redirect) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_d = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        state_d = ST_ISSUE;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = addr_q;
                        ir_valid_d = 1'b1;
                        inc_d      = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end else if (redirect) begin
                    // The memory still owes us a response; finish it before refetching.
                    state_d = ST_SQUASH;
                end
            end
            ST_HOLD: begin
                if (redirect || ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_SQUASH: begin
                req_d = 1'b1;
                if (imem_ack) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    // Strobes are gated by reset so the PC cannot move while reset is held,
    // whatever redirect and imem_ack are doing.
    assign pc_ld     = reset & redirect;
    assign pc_inc    = reset & inc_d;
    assign imem_req  = reset & req_d;
    assign pc_in     = redirect_addr;
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge. Every instruction expected to reach
// decode is queued when its memory response is driven and is compared by the
// monitor when the ir_valid/ir_ready handshake happens.
module tb_fetch_unit;

    localparam logic [31:0] IR_RESET = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_addr = '0;
    logic        pc_ld, pc_inc;
    logic [31:0] pc_in;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] ir, ir_pc;

    int   checks = 0;
    int   errors = 0;
    int   inc_cnt = 0;
    int   accept_cnt = 0;
    exp_t exp_q[$];

    fetch_unit #(.IR_RESET(IR_RESET)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_addr       (pc_addr),
        .pc_ld         (pc_ld),
        .pc_inc        (pc_inc),
        .pc_in         (pc_in),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .ir            (ir),
        .ir_pc         (ir_pc)
    );

    always #5 clk = ~clk;

    // Scoreboard side: handshakes, pc_inc pulses, strobe exclusivity.
    always @(negedge clk) begin
        if (reset) begin
            if (pc_inc) inc_cnt++;
            checks++;
            if (pc_ld && pc_inc) begin
                errors++;
                $display("FAIL ld_inc_exclusive: got pc_ld=%b pc_inc=%b, required not both 1", pc_ld, pc_inc);
            end
            if (ir_valid && ir_ready) begin
                accept_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_accept: got ir=%h ir_pc=%h, required no instruction", ir, ir_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({ir, ir_pc} !== {e.ir, e.pc}) begin
                        errors++;
                        $display("FAIL accept_data: got ir=%h ir_pc=%h, required ir=%h ir_pc=%h", ir, ir_pc, e.ir, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        imem_ack = 1'b0;
        ir_ready = 1'b0;
    endtask

    task automatic expect_fetch(input logic [31:0] word, input logic [31:0] addr);
        exp_t e;
        e.ir = word;
        e.pc = addr;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h0000_0abc;
        imem_ack = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", ir_valid); end
        checks++; if (ir !== IR_RESET) begin errors++; $display("FAIL rst_ir: got %h required %h", ir, IR_RESET); end
        checks++; if (ir_pc !== IR_RESET) begin errors++; $display("FAIL rst_ir_pc: got %h required %h", ir_pc, IR_RESET); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
        @(negedge clk);
        checks++; if (pc_ld !== 1'b0) begin errors++; $display("FAIL rst_pc_ld: got %b required 0", pc_ld); end
        checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL rst_pc_inc: got %b required 0", pc_inc); end
    endtask

    // Zero-wait fetch from address 0: ir_valid two cycles after ISSUE.
    task automatic test_basic();
        int inc0;
        next_cycle();
        reset = 1'b1;
        pc_addr = 32'h0000_0000;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_issue_req: got %b required 0", imem_req); end
        next_cycle();
        imem_ack = 1'b1;
        imem_rdata = 32'h2008_0005;
        expect_fetch(32'h2008_0005, 32'h0000_0000);
        inc0 = inc_cnt;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_wait_req: got %b required 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h required 0", imem_addr); end
        checks++; if (pc_inc !== 1'b1) begin errors++; $display("FAIL basic_pc_inc: got %b required 1", pc_inc); end
        next_cycle();
        @(negedge clk);
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", ir_valid); end
        checks++; if (ir !== 32'h2008_0005) begin errors++; $display("FAIL basic_ir: got %h required 20080005", ir); end
        checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL basic_ir_pc: got %h required 0", ir_pc); end
        checks++; if (inc_cnt - inc0 !== 1) begin errors++; $display("FAIL basic_inc_count: got %0d required 1", inc_cnt - inc0); end
    endtask

    // Decode stalls for 5 cycles; the held instruction must not move.
    task automatic test_hold_stall();
        int inc0;
        inc0 = inc_cnt;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b required 1", i, ir_valid); end
            checks++; if ({ir, ir_pc} !== {32'h2008_0005, 32'h0}) begin errors++; $display("FAIL hold_ir[%0d]: got %h/%h required 20080005/00000000", i, ir, ir_pc); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b required 0", i, imem_req); end
            checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL hold_inc[%0d]: got %b required 0", i, pc_inc); end
        end
        next_cycle();
        ir_ready = 1'b1;
        @(negedge clk);
        checks++; if (inc_cnt !== inc0) begin errors++; $display("FAIL hold_inc_count: got %0d required %0d", inc_cnt, inc0); end
    endtask

    // Memory acknowledges in the third request cycle.
    task automatic test_wait_states();
        int inc0;
        int req_cycles;
        req_cycles = 0;
        next_cycle();
        pc_addr = 32'h0000_0010;
        inc0 = inc_cnt;
        @(negedge clk);
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ws_issue_valid: got %b required 0", ir_valid); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) begin
                imem_ack = 1'b1;
                imem_rdata = 32'h8c02_0004;
                expect_fetch(32'h8c02_0004, 32'h0000_0010);
            end
            @(negedge clk);
            if (imem_req) req_cycles++;
            checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL ws_addr[%0d]: got %h required 10", i, imem_addr); end
            checks++; if (pc_inc !== (i == 2)) begin errors++; $display("FAIL ws_inc[%0d]: got %b required %b", i, pc_inc, (i == 2)); end
        end
        next_cycle();
        ir_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ws_hold_req: got %b required 0", imem_req); end
        checks++; if (req_cycles !== 3) begin errors++; $display("FAIL ws_req_cycles: got %0d required 3", req_cycles); end
        checks++; if (inc_cnt - inc0 !== 1) begin errors++; $display("FAIL ws_inc_count: got %0d required 1", inc_cnt - inc0); end
    endtask

    // Redirect while in ISSUE: no request, new PC sampled the next cycle.
    task automatic test_redirect_issue();
        next_cycle();
        pc_addr = 32'h0000_0050;
        redirect = 1'b1;
        redirect_addr = 32'h0000_0060;
        @(negedge clk);
        checks++; if ({pc_ld, pc_in} !== {1'b1, 32'h60}) begin errors++; $display("FAIL ri_pc_ld: got %b/%h required 1/00000060", pc_ld, pc_in); end
        next_cycle();
        pc_addr = 32'h0000_0060;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ri_still_issue: got req %b required 0", imem_req); end
        next_cycle();
        imem_ack = 1'b1;
        imem_rdata = 32'h2442_0001;
        expect_fetch(32'h2442_0001, 32'h0000_0060);
        @(negedge clk);
        checks++; if (imem_addr !== 32'h60) begin errors++; $display("FAIL ri_addr: got %h required 60", imem_addr); end
        next_cycle();
        ir_ready = 1'b1;
        @(negedge clk);
    endtask

    // Redirect in WAIT before the ack: the late response is squashed.
    task automatic test_redirect_wait();
        int inc0;
        next_cycle();
        pc_addr = 32'h0000_0020;
        inc0 = inc_cnt;
        @(negedge clk);
        next_cycle();
        redirect = 1'b1;
        redirect_addr = 32'h0000_0100;
        @(negedge clk);
        checks++; if ({pc_ld, pc_in} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rw_pc_ld: got %b/%h required 1/00000100", pc_ld, pc_in); end
        next_cycle();
        pc_addr = 32'h0000_0100;
        @(negedge clk);
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h20}) begin errors++; $display("FAIL rw_squash_req: got %b/%h required 1/00000020", imem_req, imem_addr); end
        next_cycle();
        imem_ack = 1'b1;
        imem_rdata = 32'hdead_beef;
        @(negedge clk);
        checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL rw_squash_inc: got %b required 0", pc_inc); end
        next_cycle();
        @(negedge clk);
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b required 0", ir_valid); end
        checks++; if (ir !== 32'h2442_0001) begin errors++; $display("FAIL rw_ir_kept: got %h required 24420001", ir); end
        next_cycle();
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        expect_fetch(32'h1111_1111, 32'h0000_0100);
        @(negedge clk);
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rw_new_addr: got %h required 100", imem_addr); end
        next_cycle();
        ir_ready = 1'b1;
        @(negedge clk);
        checks++; if (inc_cnt - inc0 !== 1) begin errors++; $display("FAIL rw_inc_count: got %0d required 1", inc_cnt - inc0); end
    endtask

    // Redirect coinciding with ack, then redirect in HOLD with ir_ready.
    task automatic test_redirect_ack();
        int acc0;
        next_cycle();
        pc_addr = 32'h0000_0030;
        @(negedge clk);
        next_cycle();
        imem_ack = 1'b1;
        imem_rdata = 32'hbad0_bad0;
        redirect = 1'b1;
        redirect_addr = 32'h0000_0200;
        @(negedge clk);
        checks++; if ({pc_ld, pc_inc} !== 2'b10) begin errors++; $display("FAIL ra_strobes: got ld=%b inc=%b required ld=1 inc=0", pc_ld, pc_inc); end
        next_cycle();
        pc_addr = 32'h0000_0200;
        @(negedge clk);
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ra_valid: got %b required 0", ir_valid); end
        checks++; if (ir !== 32'h1111_1111) begin errors++; $display("FAIL ra_ir_kept: got %h required 11111111", ir); end
        next_cycle();
        imem_ack = 1'b1;
        imem_rdata = 32'h2222_2222;
        expect_fetch(32'h2222_2222, 32'h0000_0200);
        @(negedge clk);
        next_cycle();
        ir_ready = 1'b1;
        redirect = 1'b1;
        redirect_addr = 32'h0000_0040;
        pc_addr = 32'h0000_0040;
        acc0 = accept_cnt;
        @(negedge clk);
        checks++; if (pc_ld !== 1'b1) begin errors++; $display("FAIL ra_hold_ld: got %b required 1", pc_ld); end
        next_cycle();
        @(negedge clk);
        checks++; if ({ir_valid, imem_req} !== 2'b00) begin errors++; $display("FAIL ra_hold_clear: got valid=%b req=%b required 0/0", ir_valid, imem_req); end
        checks++; if (accept_cnt - acc0 !== 1) begin errors++; $display("FAIL ra_accepts: got %0d required 1", accept_cnt - acc0); end
    endtask

    // Reset asserted in SQUASH abandons the request; fetch resumes after release.
    task automatic test_reset_squash();
        next_cycle();
        redirect = 1'b1;
        redirect_addr = 32'h0000_0500;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL rs_addr: got %h required 40", imem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rs_squash_req: got %b required 1", imem_req); end
        next_cycle();
        reset = 1'b0;
        redirect = 1'b1;
        #1;
        checks++; if ({imem_req, ir_valid, pc_ld} !== 3'b000) begin errors++; $display("FAIL rs_async: got req=%b valid=%b ld=%b required 0/0/0", imem_req, ir_valid, pc_ld); end
        checks++; if ({ir, ir_pc} !== {IR_RESET, IR_RESET}) begin errors++; $display("FAIL rs_ir: got %h/%h required %h/%h", ir, ir_pc, IR_RESET, IR_RESET); end
        @(negedge clk);
        next_cycle();
        reset = 1'b1;
        pc_addr = 32'h0000_0500;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rs_issue_req: got %b required 0", imem_req); end
        next_cycle();
        imem_ack = 1'b1;
        imem_rdata = 32'h3333_3333;
        expect_fetch(32'h3333_3333, 32'h0000_0500);
        @(negedge clk);
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h500}) begin errors++; $display("FAIL rs_resume: got %b/%h required 1/00000500", imem_req, imem_addr); end
        next_cycle();
        ir_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_wait_states();
        test_redirect_issue();
        test_redirect_wait();
        test_redirect_ack();
        test_reset_squash();
        next_cycle();
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending required 0", exp_q.size()); end
        checks++; if (accept_cnt !== 6) begin errors++; $display("FAIL accept_total: got %0d required 6", accept_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: IR_RESET, 32'h0000_0000, value of ir and ir_pc after reset (MIPS NOP).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 pc_addr  in  32  current PC register output.
REQ-005 pc_ld  out  1  PC load strobe; PC takes pc_in at next edge.
REQ-006 pc_inc  out  1  PC increment strobe; PC advances by 4 at next edge.
REQ-007 pc_in  out  32  PC load value; equals redirect_addr.
REQ-008 redirect  in  1  branch/jump redirect request, single-cycle, from decode/execute.
REQ-009 redirect_addr  in  32  redirect target address.
REQ-010 imem_req  out  1  instruction memory read request, level.
REQ-011 imem_addr  out  32  read address; stable while imem_req = 1.
REQ-012 imem_ack  in  1  read data valid this cycle; completes request.
REQ-013 imem_rdata  in  32  instruction word, valid when imem_ack = 1.
REQ-014 ir_valid  out  1  ir/ir_pc hold an instruction for decode.
REQ-015 ir_ready  in  1  decode accepts ir this cycle when ir_valid = 1.
REQ-016 ir  out  32  instruction register.
REQ-017 ir_pc  out  32  address ir was fetched from.

Function
REQ-018 FSM states SHALL be ISSUE, WAIT, HOLD, SQUASH; reset state ISSUE.
REQ-019 ISSUE: addr_q <= pc_addr; imem_req = 0; next WAIT unless redirect.
REQ-020 WAIT: imem_req = 1, imem_addr = addr_q; stay until imem_ack.
REQ-021 WAIT with imem_ack, no redirect: ir <= imem_rdata, ir_pc <= addr_q, ir_valid <= 1, pc_inc = 1 same cycle, next HOLD.
REQ-022 HOLD: ir_valid = 1; ir/ir_pc stable; on ir_ready: ir_valid <= 0, next ISSUE.
REQ-023 SQUASH: imem_req = 1, imem_addr = addr_q held; on imem_ack data discarded, next ISSUE.
REQ-024 pc_ld SHALL equal redirect in every state; pc_in = redirect_addr (combinational).
REQ-025 pc_inc SHALL be 1 only in WAIT with imem_ack = 1 and redirect = 0; pc_ld and pc_inc never both 1.
REQ-026 Redirect in ISSUE: no request issued; stay ISSUE (new PC sampled next cycle).
REQ-027 Redirect in WAIT with imem_ack: data discarded, ir_valid unchanged (0), next ISSUE.
REQ-028 Redirect in WAIT without imem_ack: next SQUASH (outstanding request completed, not abandoned).
REQ-029 Redirect in HOLD: ir_valid <= 0 regardless of ir_ready, next ISSUE.
REQ-030 Redirect in SQUASH: pc_ld pulses again; stay SQUASH until ack.
REQ-031 Latency: zero-wait memory (ack in first WAIT cycle) gives ir_valid 2 cycles after ISSUE; peak throughput 1 instruction per 3 cycles.
REQ-032 imem_req SHALL never drop before imem_ack while in WAIT/SQUASH, except on reset.

Reset
REQ-033 reset = 0 SHALL immediately force state ISSUE, ir_valid = 0, imem_req = 0, ir = IR_RESET, ir_pc = IR_RESET, addr_q = 0.
REQ-034 pc_ld = 0 and pc_inc = 0 while reset = 0, independent of redirect/imem_ack.
REQ-035 Reset mid-request abandons it; memory side tolerates dropped imem_req on reset.

Structure
REQ-036 State encodings (2-bit ISSUE=00, WAIT=01, HOLD=10, SQUASH=11) and NOP constant SHALL live in the shared CPU definitions package.
REQ-037 Single module, no sub-modules; registered ir/ir_pc/ir_valid/addr_q/state, combinational pc_ld/pc_inc/imem_req.

Verification
REQ-038 Reset release, pc_addr=0, ack in first WAIT cycle with rdata=32'h2008_0005 -> pc_inc 1 cycle, ir=32'h2008_0005, ir_pc=0, ir_valid=1 two cycles after ISSUE.
REQ-039 ir_ready held 0 for 5 cycles in HOLD -> ir, ir_pc, ir_valid stable, imem_req=0, no pc_inc.
REQ-040 ack delayed 3 cycles, pc_addr=32'h0000_0010 -> imem_req high 3 cycles, imem_addr=32'h10 constant, single pc_inc.
REQ-041 redirect to 32'h0000_0100 in WAIT, ack 2 cycles later with 32'hDEAD_BEEF -> pc_ld=1, pc_in=32'h100, state SQUASH, DEAD_BEEF never in ir, next imem_addr=32'h100.
REQ-042 redirect and imem_ack same WAIT cycle -> pc_ld=1, pc_inc=0, ir_valid stays 0; redirect in HOLD with ir_ready=1 -> ir_valid cleared, no double accept.
REQ-043 reset asserted in SQUASH mid-request -> imem_req=0, ir_valid=0, ir=IR_RESET within same cycle; fetch from pc_addr resumes after release.
